// File: rtl/decode_issue_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_buffer_pkg
// Description : Shared payload type and default configuration for the
//               decode/issue buffer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package decode_issue_buffer_pkg;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } issue_entry_t;

  localparam int unsigned c_FETCH_WIDTH      = 2;
  localparam int unsigned c_ISSUE_WIDTH      = 2;
  localparam int unsigned c_DEPTH            = 8;
  localparam int unsigned c_REDIRECT_BUBBLES = 1;
  localparam logic [31:0] c_RESET_VECTOR     = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/decode_issue_buffer_issue_ring.sv
`default_nettype none
// ============================================================================
// Module      : issue_ring
// Description : DEPTH-entry ring storage with FETCH_WIDTH write ports and
//               ISSUE_WIDTH read ports at consecutive offsets from a pointer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module issue_ring
  import decode_issue_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH = c_FETCH_WIDTH,
  parameter int ISSUE_WIDTH = c_ISSUE_WIDTH,
  parameter int DEPTH       = c_DEPTH,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic [PW-1:0]                       i_wr_ptr,
  input  logic [FETCH_WIDTH-1:0]              i_wr_en,
  input  issue_entry_t [FETCH_WIDTH-1:0]      i_wr_data,
  input  logic [PW-1:0]                       i_rd_ptr,
  output issue_entry_t [ISSUE_WIDTH-1:0]      o_rd_data
);

  issue_entry_t r_mem [DEPTH];

  // Pointer arithmetic is PW bits wide, so offsets wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (i_wr_en[k]) begin
        r_mem[i_wr_ptr + PW'(k)] <= i_wr_data[k];
      end
    end
  end

  generate
    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_rd
      assign o_rd_data[j] = r_mem[i_rd_ptr + PW'(j)];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_buffer
// Description : Fetch-PC owner and in-order decode/issue ring buffer.
//               Optional per-pop trace under DECODE_ISSUE_TRACE_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int          FETCH_WIDTH      = c_FETCH_WIDTH,
  parameter int          ISSUE_WIDTH      = c_ISSUE_WIDTH,
  parameter int          DEPTH            = c_DEPTH,
  parameter int          REDIRECT_BUBBLES = c_REDIRECT_BUBBLES,
  parameter logic [31:0] RESET_VECTOR     = c_RESET_VECTOR,
  localparam int         PW               = $clog2(DEPTH),
  localparam int         CW               = $clog2(DEPTH + 1),
  localparam int         GW               = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      redirect,
  input  logic [31:0]               redirectVector,
  input  logic                      fetchValid,
  input  logic [32*FETCH_WIDTH-1:0] fetchInstructions,
  input  logic [GW-1:0]             fetchGoodCount,
  output logic                      fetchReady,
  output logic [31:0]               requestPC,
  output logic [ISSUE_WIDTH-1:0]    issueValid,
  output logic [32*ISSUE_WIDTH-1:0] issueInstructions,
  output logic [32*ISSUE_WIDTH-1:0] issuePCs,
  input  logic [ISSUE_WIDTH-1:0]    issueGrant,
  output logic [CW-1:0]             occupancy
);

  localparam logic [3:0] c_BUBBLE_INIT = 4'(REDIRECT_BUBBLES);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc;
  logic [3:0]    r_bubble;

  logic                              w_push;
  logic [GW-1:0]                     w_good;
  logic [CW-1:0]                     w_push_n;
  logic [CW-1:0]                     w_pop;
  logic                              w_run;
  logic [FETCH_WIDTH-1:0]            w_wr_en;
  issue_entry_t [FETCH_WIDTH-1:0]    w_wr_data;
  issue_entry_t [ISSUE_WIDTH-1:0]    w_rd_data;

  // Readiness looks only at registered occupancy: same-cycle pops give no credit.
  assign fetchReady = (r_bubble == 4'd0) &&
                      ((CW'(DEPTH) - r_count) >= CW'(FETCH_WIDTH)) && !redirect;
  assign requestPC  = r_pc;
  assign occupancy  = r_count;

  assign w_good   = (fetchGoodCount > GW'(FETCH_WIDTH)) ? GW'(FETCH_WIDTH) : fetchGoodCount;
  assign w_push   = fetchValid && fetchReady;
  assign w_push_n = w_push ? CW'(w_good) : '0;

  generate
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_wr
      assign w_wr_en[k]               = w_push && (GW'(k) < w_good);
      assign w_wr_data[k].instruction = fetchInstructions[32*k +: 32];
      assign w_wr_data[k].pc          = r_pc + 32'(4 * k);
    end
    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_issue
      assign issueValid[j]             = (CW'(j) < r_count) && !redirect;
      assign issueInstructions[32*j +: 32] = w_rd_data[j].instruction;
      assign issuePCs[32*j +: 32]          = w_rd_data[j].pc;
    end
  endgenerate

  // Only the leading run of granted, valid slots retires.
  always_comb begin
    w_pop = '0;
    w_run = 1'b1;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (w_run && issueGrant[j] && issueValid[j]) begin
        w_pop = w_pop + CW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  issue_ring #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ring (
    .clock     (clock),
    .i_wr_ptr  (r_tail),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_ptr  (r_head),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_pc     <= RESET_VECTOR;
      r_bubble <= c_BUBBLE_INIT;
    end else if (redirect) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_pc     <= redirectVector;
      r_bubble <= c_BUBBLE_INIT;
    end else begin
      r_head   <= r_head + PW'(w_pop);
      r_tail   <= r_tail + PW'(w_push_n);
      r_count  <= r_count + w_push_n - w_pop;
      r_pc     <= r_pc + (32'(w_push_n) << 2);
      if (r_bubble != 4'd0) begin
        r_bubble <= r_bubble - 4'd1;
      end
    end
  end

`ifdef DECODE_ISSUE_TRACE_EN
  always @(posedge clock) begin
    if (reset && !redirect) begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (CW'(j) < w_pop) begin
          $display("Issued %h, PC: %h", w_rd_data[j].instruction, w_rd_data[j].pc);
        end
      end
    end
  end
`else
  // Trace disabled: the buffer produces no simulation output.
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_buffer.sv
`default_nettype none
// Testbench for decode_issue_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_decode_issue_buffer;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int RB    = 1;
  localparam logic [31:0] RV = 32'h100;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 redirect = 1'b0;
  logic [31:0]          redirectVector = '0;
  logic                 fetchValid = 1'b0;
  logic [32*FW-1:0]     fetchInstructions = '0;
  logic [1:0]           fetchGoodCount = '0;
  logic                 fetchReady;
  logic [31:0]          requestPC;
  logic [IW-1:0]        issueValid;
  logic [32*IW-1:0]     issueInstructions;
  logic [32*IW-1:0]     issuePCs;
  logic [IW-1:0]        issueGrant = '0;
  logic [3:0]           occupancy;

  decode_issue_buffer #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH),
    .REDIRECT_BUBBLES(RB), .RESET_VECTOR(RV)
  ) dut (
    .clock(clock), .reset(reset), .redirect(redirect),
    .redirectVector(redirectVector), .fetchValid(fetchValid),
    .fetchInstructions(fetchInstructions), .fetchGoodCount(fetchGoodCount),
    .fetchReady(fetchReady), .requestPC(requestPC), .issueValid(issueValid),
    .issueInstructions(issueInstructions), .issuePCs(issuePCs),
    .issueGrant(issueGrant), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_bub;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic model_init();
    q.delete();
    m_pc  = RV;
    m_bub = RB;
  endtask

  function automatic bit model_ready();
    return (m_bub == 0) && ((DEPTH - q.size()) >= FW) && !redirect;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    int   pops;
    int   good;
    bit   rdy;
    ent_t e;
    if (redirect) begin
      q.delete();
      m_pc  = redirectVector;
      m_bub = RB;
      return;
    end
    rdy  = model_ready();
    pops = 0;
    for (int j = 0; j < IW; j++) begin
      if (issueGrant[j] && j < q.size()) pops++;
      else break;
    end
    for (int j = 0; j < pops; j++) void'(q.pop_front());
    good = (int'(fetchGoodCount) > FW) ? FW : int'(fetchGoodCount);
    if (fetchValid && rdy) begin
      for (int k = 0; k < good; k++) begin
        e.instr = fetchInstructions[32*k +: 32];
        e.pc    = m_pc + 32'(4 * k);
        q.push_back(e);
      end
      m_pc = m_pc + 32'(4 * good);
    end
    if (m_bub > 0) m_bub--;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] vec);
    redirect = 1'b1; redirectVector = vec;
    tick();
    redirect = 1'b0;
    repeat (RB) tick();
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (requestPC !== RV) begin n_fail++; $display("FAIL reset_pc got %h want %h", requestPC, RV); end
    n_tests++;
    if (fetchReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", fetchReady); end
    n_tests++;
    if (issueValid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b want 00", issueValid); end
    n_tests++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    @(negedge clock);
    reset = 1'b1;
    model_init();
  endtask

  task automatic test_basic_push();
    #1;
    n_tests++;
    if (fetchReady !== 1'b0) begin n_fail++; $display("FAIL bubble_ready got %b want 0", fetchReady); end
    tick();
    n_tests++;
    if (fetchReady !== 1'b1) begin n_fail++; $display("FAIL post_bubble_ready got %b want 1", fetchReady); end
    fetchValid = 1'b1; fetchGoodCount = 2'd2;
    fetchInstructions = {32'hBBBB_0002, 32'hAAAA_0001};
    tick();
    fetchValid = 1'b0;
    #1;
    n_tests++;
    if (issueValid !== 2'b11) begin n_fail++; $display("FAIL push_valid got %b want 11", issueValid); end
    n_tests++;
    if (issuePCs !== {32'h104, 32'h100}) begin n_fail++; $display("FAIL push_pcs got %h want %h", issuePCs, {32'h104, 32'h100}); end
    n_tests++;
    if (issueInstructions !== {32'hBBBB_0002, 32'hAAAA_0001}) begin n_fail++; $display("FAIL push_instr got %h", issueInstructions); end
    n_tests++;
    if (requestPC !== 32'h108) begin n_fail++; $display("FAIL push_reqpc got %h want 108", requestPC); end
    issueGrant = 2'b11;
    tick();
    issueGrant = 2'b00;
    #1;
    n_tests++;
    if (occupancy !== 4'd0 || issueValid !== 2'b00) begin n_fail++; $display("FAIL drain got occ %0d valid %b want 0 00", occupancy, issueValid); end
  endtask

  task automatic test_good_count();
    do_redirect(32'h200);
    fetchValid = 1'b1; fetchGoodCount = 2'd0;
    fetchInstructions = {32'h2222_2222, 32'h1111_1111};
    tick();
    n_tests++;
    if (occupancy !== 4'd0 || requestPC !== 32'h200) begin n_fail++; $display("FAIL good0 got occ %0d pc %h want 0 200", occupancy, requestPC); end
    fetchGoodCount = 2'd1;
    tick();
    fetchValid = 1'b0;
    #1;
    n_tests++;
    if (occupancy !== 4'd1 || issueValid !== 2'b01) begin n_fail++; $display("FAIL good1_occ got occ %0d valid %b want 1 01", occupancy, issueValid); end
    n_tests++;
    if (issuePCs[31:0] !== 32'h200 || issueInstructions[31:0] !== 32'h1111_1111) begin n_fail++; $display("FAIL good1_entry got pc %h instr %h want 200 11111111", issuePCs[31:0], issueInstructions[31:0]); end
    n_tests++;
    if (requestPC !== 32'h204) begin n_fail++; $display("FAIL good1_reqpc got %h want 204", requestPC); end
  endtask

  task automatic test_grant_prefix();
    fetchValid = 1'b1; fetchGoodCount = 2'd2;
    fetchInstructions = {32'h3333_0208, 32'h3333_0204};
    tick();
    fetchValid = 1'b0;
    issueGrant = 2'b10;
    tick();
    n_tests++;
    if (occupancy !== 4'd3 || issuePCs[31:0] !== 32'h200) begin n_fail++; $display("FAIL grant10 got occ %0d pc0 %h want 3 200", occupancy, issuePCs[31:0]); end
    issueGrant = 2'b01;
    tick();
    issueGrant = 2'b00;
    #1;
    n_tests++;
    if (occupancy !== 4'd2 || issuePCs[31:0] !== 32'h204) begin n_fail++; $display("FAIL grant01 got occ %0d pc0 %h want 2 204", occupancy, issuePCs[31:0]); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] want;
    do_redirect(32'h1000);
    // Shift pointers by one so a later beat straddles index 7/0.
    fetchValid = 1'b1; fetchGoodCount = 2'd1; fetchInstructions = {32'h0, 32'hF000_1000};
    tick();
    fetchValid = 1'b0; issueGrant = 2'b01;
    tick();
    issueGrant = 2'b00;
    for (int b = 0; b < 4; b++) begin
      fetchValid = 1'b1; fetchGoodCount = 2'd2;
      fetchInstructions = {32'hF000_0000 | 32'(2*b+1), 32'hF000_0000 | 32'(2*b)};
      tick();
    end
    #1;
    n_tests++;
    if (occupancy !== 4'd8 || fetchReady !== 1'b0) begin n_fail++; $display("FAIL full got occ %0d ready %b want 8 0", occupancy, fetchReady); end
    tick();
    fetchValid = 1'b0;
    n_tests++;
    if (occupancy !== 4'd8 || requestPC !== 32'h1024) begin n_fail++; $display("FAIL full_hold got occ %0d pc %h want 8 1024", occupancy, requestPC); end
    issueGrant = 2'b11;
    tick();
    issueGrant = 2'b00;
    #1;
    n_tests++;
    if (occupancy !== 4'd6 || fetchReady !== 1'b1) begin n_fail++; $display("FAIL unfull got occ %0d ready %b want 6 1", occupancy, fetchReady); end
    fetchValid = 1'b1; fetchGoodCount = 2'd2; fetchInstructions = {32'hF000_0009, 32'hF000_0008};
    tick();
    fetchValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want = 32'h100C + 32'(8 * i);
      #1;
      n_tests++;
      if (issuePCs !== {want + 32'h4, want}) begin n_fail++; $display("FAIL wrap_drain%0d got %h want %h", i, issuePCs, {want + 32'h4, want}); end
      issueGrant = 2'b11;
      tick();
      issueGrant = 2'b00;
    end
  endtask

  task automatic test_redirect();
    do_redirect(32'h300);
    for (int b = 0; b < 3; b++) begin
      fetchValid = 1'b1; fetchGoodCount = (b == 2) ? 2'd1 : 2'd2;
      fetchInstructions = {$urandom, $urandom};
      tick();
    end
    fetchValid = 1'b0;
    #1;
    n_tests++;
    if (occupancy !== 4'd5) begin n_fail++; $display("FAIL pre_redirect_occ got %0d want 5", occupancy); end
    redirect = 1'b1; redirectVector = 32'h4000; fetchValid = 1'b1; fetchGoodCount = 2'd2; issueGrant = 2'b11;
    #1;
    n_tests++;
    if (issueValid !== 2'b00 || fetchReady !== 1'b0) begin n_fail++; $display("FAIL redirect_same got valid %b ready %b want 00 0", issueValid, fetchReady); end
    tick();
    redirect = 1'b0; fetchValid = 1'b0; issueGrant = 2'b00;
    #1;
    n_tests++;
    if (occupancy !== 4'd0 || requestPC !== 32'h4000 || fetchReady !== 1'b0) begin n_fail++; $display("FAIL redirect_next got occ %0d pc %h ready %b want 0 4000 0", occupancy, requestPC, fetchReady); end
    tick();
    n_tests++;
    if (occupancy !== 4'd0 || fetchReady !== 1'b1) begin n_fail++; $display("FAIL redirect_after got occ %0d ready %b want 0 1", occupancy, fetchReady); end
  endtask

  task automatic test_random();
    logic [IW-1:0] exp_valid;
    for (int c = 0; c < 400; c++) begin
      redirect          = ($urandom_range(0, 24) == 0);
      redirectVector    = $urandom & 32'hFFFF_FFFC;
      fetchValid        = $urandom_range(0, 3) != 0;
      fetchGoodCount    = 2'($urandom_range(0, 3));
      fetchInstructions = {$urandom, $urandom};
      issueGrant        = IW'($urandom_range(0, 3));
      #1;
      for (int j = 0; j < IW; j++) exp_valid[j] = (j < q.size()) && !redirect;
      n_tests++;
      if (issueValid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, issueValid, exp_valid); end
      n_tests++;
      if (fetchReady !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, fetchReady, model_ready()); end
      n_tests++;
      if (occupancy !== 4'(q.size()) || requestPC !== m_pc) begin n_fail++; $display("FAIL rnd_state c%0d got occ %0d pc %h want %0d %h", c, occupancy, requestPC, q.size(), m_pc); end
      for (int j = 0; j < IW; j++) begin
        if (j < q.size()) begin
          n_tests++;
          if (issuePCs[32*j +: 32] !== q[j].pc || issueInstructions[32*j +: 32] !== q[j].instr) begin
            n_fail++;
            $display("FAIL rnd_slot%0d c%0d got pc %h instr %h want %h %h", j, c, issuePCs[32*j +: 32], issueInstructions[32*j +: 32], q[j].pc, q[j].instr);
          end
        end
      end
      tick();
    end
    redirect = 1'b0; fetchValid = 1'b0; issueGrant = 2'b00;
  endtask

  task automatic test_async_reset();
    do_redirect(32'h500);
    fetchValid = 1'b1; fetchGoodCount = 2'd2; fetchInstructions = {32'h5555_0001, 32'h5555_0000};
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (occupancy !== 4'd0 || issueValid !== 2'b00 || requestPC !== RV || fetchReady !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got occ %0d valid %b pc %h ready %b want 0 00 %h 0", occupancy, issueValid, requestPC, fetchReady, RV);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; fetchValid = 1'b0;
    model_init();
    tick();
    n_tests++;
    if (occupancy !== 4'd0 || requestPC !== RV || fetchReady !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset got occ %0d pc %h ready %b want 0 %h 1", occupancy, requestPC, fetchReady, RV);
    end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_good_count();
    test_grant_prefix();
    test_fill_wrap();
    test_redirect();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
